hc595_scan_ctrl: RTL and testbench

Scan controller for a 7-segment display driven through two daisy-chained 74HC595 shift registers (segment byte + digit-select byte). It multiplexes NUM_DIGITS hex digits on a fixed refresh period and sequences the serial shift/latch protocol on clk595/out595/lock595. It sits between the application's display registers and the board's 595 pins, replacing hand-driven shift logic in the top level.

---
 rtl/hc595_pkg.sv | 24 ++
 rtl/hc595_scan_ctrl_if.sv | 25 ++
 rtl/hc595_shifter.sv | 93 +++++++++
 rtl/hc595_scan_ctrl.sv | 84 ++++++++
 tb/tb_hc595_scan_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 display scan controller.
package hc595_pkg;

  // Bits per serial frame: segment byte (far 595) followed by digit-select byte (near 595).
  localparam int FRAME_BITS = 16;

  // Segment byte value that lights nothing, before any active-low inversion.
  localparam logic [7:0] SEG_OFF_HI = 8'h00;

  // Hex digit to {dp,g,f,e,d,c,b,a}, active-high, dp clear. Entry n sits at SEG_LUT[n].
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

endpackage

// File: rtl/hc595_scan_ctrl_if.sv
// Display-data inputs and 595 pin outputs of the scan controller.
interface hc595_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank;
  logic                    clk595;
  logic                    out595;
  logic                    lock595;
  logic                    busy;
  logic                    frame_done;

  // Application side: supplies digits, observes the pins and status.
  modport master (
    output digit_data, dp_mask, blank,
    input  clk595, out595, lock595, busy, frame_done
  );

  // Controller side.
  modport slave (
    input  digit_data, dp_mask, blank,
    output clk595, out595, lock595, busy, frame_done
  );
endinterface

// File: rtl/hc595_shifter.sv
// Serialises one 16-bit frame MSB first onto the 595 pins, then strobes the latch.
module hc595_shifter
  import hc595_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_BITS-1:0] word,
  input  logic                  start,
  output logic                  accept,
  output logic                  clk595,
  output logic                  out595,
  output logic                  lock595,
  output logic                  busy,
  output logic                  done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS);

  state_t                state;
  state_t                state_next;
  logic [DW-1:0]         div_cnt;
  logic                  div_last;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] word_q;

  assign div_last = (div_cnt == DW'(CLK_DIV - 1));

  // A request is taken in the cycle the shifter leaves IDLE for LOAD.
  assign accept = (state == IDLE) && start;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:     if (start) state_next = LOAD;
      LOAD:     state_next = SHIFT_LO;
      SHIFT_LO: if (div_last) state_next = SHIFT_HI;
      SHIFT_HI: if (div_last) state_next = (bit_cnt == '0) ? LATCH : SHIFT_LO;
      LATCH:    if (div_last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Phase divider, frame snapshot, bit counter and serial data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      word_q  <= '0;
      out595  <= 1'b0;
    end else begin
      if (state_next != state || state == IDLE) div_cnt <= '0;
      else                                      div_cnt <= div_cnt + 1'b1;

      if (state == LOAD) begin
        word_q  <= word;
        bit_cnt <= BW'(FRAME_BITS - 1);
        out595  <= word[FRAME_BITS-1];
      end else if (state == SHIFT_HI && div_last && bit_cnt != '0) begin
        // New data is presented as clk595 falls, a full half-period before the next rise.
        bit_cnt <= bit_cnt - 1'b1;
        out595  <= word_q[bit_cnt - 1'b1];
      end
    end
  end

  // Pin and status registers, decoded from the state being entered so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk595  <= 1'b0;
      lock595 <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      clk595  <= (state_next == SHIFT_HI);
      lock595 <= (state_next == LATCH);
      busy    <= (state_next != IDLE);
      done    <= (state == LATCH) && div_last;
    end
  end

endmodule

// File: rtl/hc595_scan_ctrl.sv
// Multiplexed 7-segment scan controller driving two daisy-chained 74HC595s.
module hc595_scan_ctrl
  import hc595_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int SCAN_CYCLES    = 50000,
  parameter int NUM_DIGITS     = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic              clk,
  input logic              rst,
  hc595_scan_ctrl_if.slave bus
);

  localparam int TW = $clog2(SCAN_CYCLES);

  logic [TW-1:0]         timer;
  logic                  scan_tick;
  logic                  pending;
  logic [2:0]            idx;
  logic                  accept;
  logic                  frame_done;
  logic [3:0]            nibble;
  logic                  dp;
  logic [7:0]            seg_hi;
  logic [7:0]            seg;
  logic [7:0]            sel;
  logic [FRAME_BITS-1:0] word;

  assign scan_tick      = (timer == TW'(SCAN_CYCLES - 1));
  assign bus.frame_done = frame_done;

  // Free-running digit-slot timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            timer <= '0;
    else if (scan_tick) timer <= '0;
    else                timer <= timer + 1'b1;
  end

  // One-deep refresh request; a tick in the same cycle as the accept wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= 1'b0;
    else     pending <= scan_tick | (pending & ~accept);
  end

  // Digit index advances once per completed frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             idx <= '0;
    else if (frame_done) idx <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
  end

  // Frame word for the current digit; the shifter snapshots it during LOAD.
  always_comb begin
    nibble = '0;
    dp     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) begin
        nibble = bus.digit_data[4*i +: 4];
        dp     = bus.dp_mask[i];
      end
    end
    seg_hi = SEG_LUT[nibble] | {dp, 7'b0};
    if (bus.blank) seg_hi = SEG_OFF_HI;
    seg  = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    sel  = 8'b1 << idx;
    word = {seg, sel};
  end

  hc595_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .word    (word),
    .start   (pending),
    .accept  (accept),
    .clk595  (bus.clk595),
    .out595  (bus.out595),
    .lock595 (bus.lock595),
    .busy    (bus.busy),
    .done    (frame_done)
  );

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Scoreboard bench: the driver predicts each latched 595 word, a pin-level monitor checks it.
module tb_hc595_scan_ctrl;

  localparam int CLK_DIV     = 2;
  localparam int SCAN_CYCLES = 100;
  localparam int NUM_DIGITS  = 4;
  localparam int FRAME_LEN   = 1 + 32*CLK_DIV + CLK_DIV;
  localparam int FIRST_LOAD  = SCAN_CYCLES + 1;
  localparam int NUM_FRAMES  = 24;

  typedef struct {
    logic [15:0] word;
    int          load_cyc;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   lock_total = 0;
  int   done_total = 0;
  frame_t exp_q[$];

  logic [7:0] lut [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  hc595_scan_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

  hc595_scan_ctrl #(
    .CLK_DIV        (CLK_DIV),
    .SCAN_CYCLES    (SCAN_CYCLES),
    .NUM_DIGITS     (NUM_DIGITS),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle number since reset release: cycle n lies after the n-th rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word the two 595s should hold for one digit: segment pins are active-low, select is one-hot.
  function automatic logic [15:0] model_word(input logic [15:0] digits, input logic [3:0] dps,
                                             input logic blank, input int idx);
    logic [3:0] nib;
    logic [7:0] lit;
    nib = digits[4*idx +: 4];
    lit = lut[nib];
    if (dps[idx]) lit = lit + 8'h80;
    if (blank)    lit = 8'h00;
    return {8'hFF - lit, 8'(1 << idx)};
  endfunction

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_pins_low(input string tag);
    check({tag, "_clk595"},     32'(bus.clk595),     0);
    check({tag, "_out595"},     32'(bus.out595),     0);
    check({tag, "_lock595"},    32'(bus.lock595),    0);
    check({tag, "_busy"},       32'(bus.busy),       0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
  endtask

  // Set the inputs ahead of LOAD for frame f, predict its word, then disturb them mid-shift.
  task automatic run_frame(input int f, input int mode);
    logic [15:0] d;
    logic [3:0]  m;
    logic        b;
    frame_t      e;
    case (mode)
      0:       begin d = 16'h3210;           m = 4'b0000;                b = 1'b0; end
      1:       begin d = 16'h3210;           m = 4'b0010;                b = 1'b0; end
      2:       begin d = 16'($urandom);      m = 4'($urandom);           b = 1'b1; end
      default: begin d = 16'($urandom);      m = 4'($urandom);           b = ($urandom_range(0, 3) == 0); end
    endcase
    wait_cyc(FIRST_LOAD - 10 + SCAN_CYCLES*f);
    bus.digit_data = d;
    bus.dp_mask    = m;
    bus.blank      = b;
    e.word     = model_word(d, m, b, f % NUM_DIGITS);
    e.load_cyc = FIRST_LOAD + SCAN_CYCLES*f;
    exp_q.push_back(e);
    wait_cyc(FIRST_LOAD + 20 + SCAN_CYCLES*f);
    bus.digit_data = 16'($urandom);
    bus.dp_mask    = 4'($urandom);
    bus.blank      = 1'($urandom);
  endtask

  // Driver.
  initial begin : driver
    bus.digit_data = '0;
    bus.dp_mask    = '0;
    bus.blank      = 1'b0;
    repeat (3) @(negedge clk);
    check_pins_low("reset");
    rst = 1'b0;

    for (int f = 0; f < NUM_FRAMES; f++) begin
      if (f < 5)       run_frame(f, 0);
      else if (f == 5) run_frame(f, 1);
      else if (f < 10) run_frame(f, 2);
      else             run_frame(f, 3);
    end

    // Abort the next frame while bit 7 is on the wire.
    wait_cyc(FIRST_LOAD - 10 + SCAN_CYCLES*NUM_FRAMES);
    bus.digit_data = 16'($urandom);
    begin
      frame_t e;
      e.word     = model_word(bus.digit_data, bus.dp_mask, bus.blank, NUM_FRAMES % NUM_DIGITS);
      e.load_cyc = FIRST_LOAD + SCAN_CYCLES*NUM_FRAMES;
      exp_q.push_back(e);
    end
    wait_cyc(FIRST_LOAD + 1 + (15 - 7)*2*CLK_DIV + SCAN_CYCLES*NUM_FRAMES);
    #1 rst = 1'b1;
    #1 check_pins_low("abort");
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // After the abort, scanning restarts from digit 0 on the normal schedule.
    run_frame(0, 3);
    run_frame(1, 3);
    wait_cyc(FIRST_LOAD + SCAN_CYCLES + FRAME_LEN + 10);

    check("lock595_pulses", 32'(lock_total), 32'(NUM_FRAMES + 2));
    check("frame_done_pulses", 32'(done_total), 32'(NUM_FRAMES + 2));
    check("frames_left", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Monitor: models the 595 chain from the pins and scores each frame.
  initial begin : monitor
    frame_t      cur;
    logic [15:0] sh;
    logic        c, o, l, b, d;
    logic        pc, po, pl, pb;
    int          rises, lock_w, busy_w, perr, last_chg;
    bit          in_frame;
    sh = '0; pc = 0; po = 0; pl = 0; pb = 0;
    rises = 0; lock_w = 0; busy_w = 0; perr = 0; last_chg = 0; in_frame = 0;
    cur.word = '0; cur.load_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pc = 0; po = 0; pl = 0; pb = 0; in_frame = 0; last_chg = 0;
      end else begin
        c = bus.clk595; o = bus.out595; l = bus.lock595; b = bus.busy; d = bus.frame_done;

        if (o != po) begin
          if (c) perr++;
          last_chg = cyc;
        end
        if (c && !pc) begin
          rises++;
          if (cyc - last_chg < CLK_DIV) perr++;
          sh = {sh[14:0], o};
        end
        if (c && l) perr++;

        if (b && !pb) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_expected: busy rose at cycle %0d, want no frame", cyc);
            in_frame = 0;
          end else begin
            cur = exp_q.pop_front();
            in_frame = 1;
            check("frame_start_cycle", 32'(cyc), 32'(cur.load_cyc));
          end
          rises = 0; lock_w = 0; busy_w = 0; perr = 0;
        end
        if (b) busy_w++;
        if (l) lock_w++;

        if (l && !pl) begin
          lock_total++;
          if (in_frame) begin
            check("clk595_rises", 32'(rises), 16);
            check("latched_word", 32'(sh), 32'(cur.word));
          end
        end

        if (!b && pb && in_frame) begin
          check("busy_width", 32'(busy_w), 32'(FRAME_LEN));
          check("lock595_width", 32'(lock_w), 32'(CLK_DIV));
          check("protocol_errors", 32'(perr), 0);
        end

        if (d) begin
          done_total++;
          if (in_frame) check("frame_done_cycle", 32'(cyc), 32'(cur.load_cyc + FRAME_LEN));
          in_frame = 0;
        end

        pc = c; po = o; pl = l; pb = b;
      end
    end
  end

endmodule
